freq_sweep: RTL and testbench
=============================

Name: freq_sweep

Overview:
Frequency sweep generator that sits directly upstream of the phase-accumulator NCO and drives its 32-bit frequency control word. It steps the control word linearly from a start value to a stop value. Each value is held for a programmable dwell time. Supports single-shot, repeating sawtooth and continuous triangle (up/down) sweeps, giving chirp and swept-sine stimulus without CPU involvement.

Parameters:
W, 32, control word width; must match NCO control width
DWELL_W, 16, width of dwell counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
start  in  1  single-cycle request to begin a sweep; honoured only when idle
abort  in  1  stop sweep immediately; priority over start
f_start  in  W  first control word of sweep
f_stop  in  W  target control word of sweep
f_step  in  W  unsigned magnitude added or subtracted per step
dwell  in  DWELL_W  extra cycles each value is held (hold time = dwell+1)
mode  in  2  00 single, 01 repeat sawtooth, 10 triangle, 11 treated as single
control  out  W  frequency control word to NCO (registered)
busy  out  1  high while a sweep is active
done  out  1  one-cycle pulse on normal completion of a single sweep
dir_down  out  1  current step direction (1 = decreasing)

Behaviour:
- Reset (reset==0 at clk edge): control=0, busy=0, done=0, dir_down=0, state IDLE, dwell counter=0. Applies mid-sweep; no done pulse.
- States: IDLE, DWELL. All outputs registered.
- IDLE: control holds its last value; busy=0.
  - start=1 and abort=0 latches f_start/f_stop/f_step/dwell/mode into shadow registers.
  - Next cycle: control=f_start, busy=1, cnt=dwell, dir_down=(f_stop<f_start), state DWELL.
  - Input changes after the start cycle are ignored until the next start.
- DWELL: if cnt!=0, cnt decrements and control holds. If cnt==0, a step event occurs and cnt reloads to dwell. Each control value is therefore present exactly dwell+1 cycles.
- Step event, not at target:
  - Up: compute control+f_step in W+1 bits. If the result is >= target or overflows, control=target; else control=sum.
  - Down: if f_step > control or control-f_step <= target, control=target; else control-=f_step.
  - f_step==0: control jumps directly to target; no hang.
  - control never overshoots target and never wraps.
- Step event, control==target (end of leg):
  - single/11: state IDLE, busy=0, done=1 for that cycle, control holds target.
  - repeat: control=f_start and continues; busy stays 1; no done.
  - triangle: target swaps between f_stop and f_start, dir_down toggles, and a normal step is taken from the current value in the new direction (the endpoint is not held twice). Runs until abort.
- f_start==f_stop:
  - single: value held dwell+1 cycles, then done.
  - repeat/triangle: control is constant; busy stays 1.
- Triangle direction: at each endpoint, dir_down=(new target < control).
- abort=1 in any state: next cycle state IDLE, busy=0, done=0, control holds the current value. Simultaneous start is ignored.
- start while busy: ignored; no restart.
- done and busy never both 1.

Test Plan:
- Reset: assert reset=0 for 2 cycles mid-sweep -> control=0, busy=0, done=0 next cycle; start ignored while reset=0.
- Single up: f_start=0x100, f_stop=0x400, f_step=0x100, dwell=2, mode=00, start at cycle 0 -> control 0x100 for cycles 1-3, 0x200 for 4-6, 0x300 for 7-9, 0x400 for 10-12; done=1 and busy=0 at cycle 13.
- Clamp/no overflow: f_start=0xFFFF_FF00, f_stop=0xFFFF_FFF0, f_step=0x80, dwell=0 -> control 0xFFFF_FF00, 0xFFFF_FF80, 0xFFFF_FFF0, then done; no wrap to small values.
- Triangle: f_start=10, f_stop=30, f_step=10, dwell=0, mode=10 -> control 10,20,30,20,10,20,30...; dir_down toggles on the cycles after 30 and after 10; busy stays 1.
- Repeat down plus abort: f_start=50, f_stop=20, f_step=20, dwell=0, mode=01 -> 50,30,20,50,30...; abort while control=30 -> control stays 30, busy=0 next cycle, no done.
- Edge cases: f_step=0 single sweep 5 to 9, dwell=1 -> 5,5,9,9, then done. start pulsed while busy -> sweep unaffected. start and abort together in IDLE -> remains idle.

Source files
------------

// File: rtl/freq_sweep.sv
// Linear frequency sweep generator that drives the NCO control word.
// Modes: single-shot, repeating sawtooth, or continuous triangle.
module freq_sweep #(
   parameter int W       = 32,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [W-1:0]       f_start,
   input  logic [W-1:0]       f_stop,
   input  logic [W-1:0]       f_step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [1:0]         mode,
   output logic [W-1:0]       control,
   output logic               busy,
   output logic               done,
   output logic               dir_down
);

   typedef enum logic {
      IDLE,
      DWELL
   } state_t;

   localparam logic [1:0] MODE_REPEAT   = 2'b01;
   localparam logic [1:0] MODE_TRIANGLE = 2'b10;

   state_t             state_q, state_d;
   logic [W-1:0]       control_q, control_d;
   logic [W-1:0]       target_q, target_d;
   logic [W-1:0]       fStart_q, fStart_d;
   logic [W-1:0]       fStop_q, fStop_d;
   logic [W-1:0]       fStep_q, fStep_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [1:0]         mode_q, mode_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dirDown_q, dirDown_d;

   logic               atTarget;
   logic               turnAround;
   logic [W-1:0]       legTarget;
   logic               legDown;
   logic [W-1:0]       stepTarget;
   logic               stepDown;
   logic [W:0]         upSum;
   logic [W-1:0]       stepResult;

   // A triangle endpoint swaps the target and steps immediately, so the
   // step datapath must see the new leg's target and direction that cycle.
   always_comb begin
      atTarget   = (control_q == target_q);
      turnAround = atTarget && (mode_q == MODE_TRIANGLE);
      legTarget  = (target_q == fStop_q) ? fStart_q : fStop_q;
      legDown    = (legTarget < control_q);
      stepTarget = turnAround ? legTarget : target_q;
      stepDown   = turnAround ? legDown : dirDown_q;
      upSum      = {1'b0, control_q} + {1'b0, fStep_q};
      stepResult = stepTarget;
      if (fStep_q == '0) begin
         stepResult = stepTarget;
      end else if (!stepDown) begin
         if (!upSum[W] && (upSum[W-1:0] < stepTarget)) begin
            stepResult = upSum[W-1:0];
         end
      end else begin
         if ((fStep_q <= control_q) && ((control_q - fStep_q) > stepTarget)) begin
            stepResult = control_q - fStep_q;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      control_d = control_q;
      target_d  = target_q;
      fStart_d  = fStart_q;
      fStop_d   = fStop_q;
      fStep_d   = fStep_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dirDown_d = dirDown_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start && !abort) begin
               fStart_d  = f_start;
               fStop_d   = f_stop;
               fStep_d   = f_step;
               dwell_d   = dwell;
               mode_d    = mode;
               target_d  = f_stop;
               control_d = f_start;
               cnt_d     = dwell;
               dirDown_d = (f_stop < f_start);
               busy_d    = 1'b1;
               state_d   = DWELL;
            end
         end
         DWELL: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else begin
               cnt_d = dwell_q;
               if (!atTarget) begin
                  control_d = stepResult;
               end else if (mode_q == MODE_REPEAT) begin
                  control_d = fStart_q;
               end else if (mode_q == MODE_TRIANGLE) begin
                  target_d  = legTarget;
                  dirDown_d = legDown;
                  control_d = stepResult;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         control_q <= '0;
         target_q  <= '0;
         fStart_q  <= '0;
         fStop_q   <= '0;
         fStep_q   <= '0;
         dwell_q   <= '0;
         cnt_q     <= '0;
         mode_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dirDown_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         control_q <= control_d;
         target_q  <= target_d;
         fStart_q  <= fStart_d;
         fStop_q   <= fStop_d;
         fStep_q   <= fStep_d;
         dwell_q   <= dwell_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dirDown_q <= dirDown_d;
      end
   end

   assign control  = control_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign dir_down = dirDown_q;

endmodule

// File: tb/tb_freq_sweep.sv
// Directed self-checking bench for freq_sweep; expected values are hand-computed.
module tb_freq_sweep;

   localparam int W       = 32;
   localparam int DWELL_W = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               abort;
   logic [W-1:0]       fStart;
   logic [W-1:0]       fStop;
   logic [W-1:0]       fStep;
   logic [DWELL_W-1:0] dwell;
   logic [1:0]         mode;
   logic [W-1:0]       control;
   logic               busy;
   logic               done;
   logic               dirDown;

   int total = 0;
   int bad   = 0;

   freq_sweep #(.W(W), .DWELL_W(DWELL_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .f_start  (fStart),
      .f_stop   (fStop),
      .f_step   (fStep),
      .dwell    (dwell),
      .mode     (mode),
      .control  (control),
      .busy     (busy),
      .done     (done),
      .dir_down (dirDown)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // checkDir=0 leaves direction unchecked where its value is unspecified
   task automatic checkOutput(input string tag, input logic [W-1:0] expControl,
                              input logic expBusy, input logic expDone,
                              input logic expDir, input logic checkDir);
      logic [W+2:0] observed;
      logic [W+2:0] expected;
      observed = {control, busy, done, checkDir ? dirDown : expDir};
      expected = {expControl, expBusy, expDone, expDir};
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Loads the sweep setup and pulses start; returns positioned at cycle 1
   task automatic applyStimulus(input logic [W-1:0] s, input logic [W-1:0] e,
                                input logic [W-1:0] st, input logic [DWELL_W-1:0] d,
                                input logic [1:0] m);
      fStart = s;
      fStop  = e;
      fStep  = st;
      dwell  = d;
      mode   = m;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   logic [W-1:0] triCtl[8];
   logic         triDir[8];
   logic [W-1:0] repCtl[5];

   initial begin
      triCtl = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd20, 32'd30, 32'd20};
      triDir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      repCtl = '{32'd50, 32'd30, 32'd20, 32'd50, 32'd30};

      reset  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      fStart = '0;
      fStop  = '0;
      fStep  = '0;
      dwell  = '0;
      mode   = '0;
      tick();
      tick();
      checkOutput("reset_state", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      tick();
      checkOutput("idle_after_reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] single up sweep with busy restart attempt");
      applyStimulus(32'h100, 32'h400, 32'h100, 16'd2, 2'b00);
      fStart = 32'h9999;
      fStop  = 32'h1;
      fStep  = 32'h5;
      dwell  = 16'd0;
      mode   = 2'b10;
      for (int c = 1; c <= 12; c++) begin
         checkOutput($sformatf("single_up_c%0d", c), W'(32'h100 * ((c - 1) / 3 + 1)),
                     1'b1, 1'b0, 1'b0, 1'b1);
         start = (c == 5);
         tick();
      end
      start = 1'b0;
      checkOutput("single_up_done", 32'h400, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("single_up_done_pulse_ends", 32'h400, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] clamp at top of range");
      applyStimulus(32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h80, 16'd0, 2'b00);
      checkOutput("clamp_c1", 32'hFFFF_FF00, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("clamp_c2", 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("clamp_c3", 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("clamp_done", 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("[TB] triangle sweep then abort");
      applyStimulus(32'd10, 32'd30, 32'd10, 16'd0, 2'b10);
      for (int c = 0; c < 8; c++) begin
         checkOutput($sformatf("triangle_c%0d", c + 1), triCtl[c], 1'b1, 1'b0, triDir[c], 1'b1);
         if (c < 7) tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("triangle_abort", 32'd20, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] repeat down sweep then abort");
      applyStimulus(32'd50, 32'd20, 32'd20, 16'd0, 2'b01);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("repeat_c%0d", c + 1), repCtl[c], 1'b1, 1'b0, 1'b1, 1'b1);
         if (c < 4) tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("repeat_abort", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("repeat_abort_no_done", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] start with abort while idle");
      fStart = 32'd77;
      start  = 1'b1;
      abort  = 1'b1;
      tick();
      start  = 1'b0;
      abort  = 1'b0;
      checkOutput("start_abort_idle", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("start_abort_idle_2", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] zero step jumps to target");
      applyStimulus(32'd5, 32'd9, 32'd0, 16'd1, 2'b00);
      checkOutput("zero_step_c1", 32'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("zero_step_c2", 32'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("zero_step_c3", 32'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("zero_step_c4", 32'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("zero_step_done", 32'd9, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("[TB] equal endpoints single sweep");
      applyStimulus(32'd7, 32'd7, 32'd1, 16'd1, 2'b11);
      checkOutput("equal_c1", 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("equal_c2", 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("equal_done", 32'd7, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("[TB] reset in the middle of a sweep");
      applyStimulus(32'h100, 32'h400, 32'h100, 16'd2, 2'b00);
      tick();
      tick();
      tick();
      reset = 1'b0;
      start = 1'b1;
      tick();
      checkOutput("mid_reset_c1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("mid_reset_c2", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      start = 1'b0;
      tick();
      checkOutput("mid_reset_release", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
